// File: rtl/shared_reg_pkg.sv
// Shared definitions for the shared-register arbiter: FSM encoding and default sizing.
package shared_reg_pkg;
  localparam int N_DEF        = 4;
  localparam int WIDTH_DEF    = 8;
  localparam int MAX_HOLD_DEF = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    COOLDOWN = 2'd2
  } state_e;
endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping mod N.
module rr_pick
  import shared_reg_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] win_idx,
  output logic          any
);
  int p;

  // Walk from lowest priority to highest so the last hit is the ptr-ordered winner.
  always_comb begin
    win     = '0;
    win_idx = '0;
    any     = |req;
    p       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      p = (int'(ptr) + k) % N;
      if (req[p]) begin
        win     = '0;
        win[p]  = 1'b1;
        win_idx = IW'(p);
      end
    end
  end
endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owned shared register with per-owner hold limit and one-cycle cooldown.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           wr_en,
  input  logic [N*WIDTH-1:0]     wdata,
  output logic [N-1:0]           gnt,
  output logic [$clog2(N)-1:0]   owner_id,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic                   timeout
);
  localparam int IW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  ptr_q, ptr_d, ptr_nxt;
  logic [HW-1:0]  hold_q, hold_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic           q_valid_q, q_valid_d;
  logic           timeout_q, timeout_d;

  logic [N-1:0]   pick_win;
  logic [IW-1:0]  pick_idx;
  logic           pick_any;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  assign ptr_nxt = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_any) begin
          gnt_d   = pick_win;
          owner_d = pick_idx;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Saturate so the counter can never wrap back into a fresh-grant value.
        hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + HW'(1);
        if (!req[owner_q]) begin
          gnt_d   = '0;
          ptr_d   = ptr_nxt;
          state_d = COOLDOWN;
        end else begin
          if (wr_en[owner_q]) begin
            q_d       = wdata[int'(owner_q)*WIDTH +: WIDTH];
            q_valid_d = 1'b1;
          end
          if (hold_q == HOLD_LAST) begin
            gnt_d     = '0;
            timeout_d = 1'b1;
            ptr_d     = ptr_nxt;
            state_d   = COOLDOWN;
          end
        end
      end
      COOLDOWN: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt      = gnt_q;
  assign owner_id = owner_q;
  assign q        = q_q;
  assign q_valid  = q_valid_q;
  assign timeout  = timeout_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter at default sizing (N=4, WIDTH=8, MAX_HOLD=16).
module tb_shared_reg_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, wr_en;
  logic [N*W-1:0] wdata;
  logic [N-1:0]  gnt;
  logic [1:0]    owner_id;
  logic [W-1:0]  q;
  logic          q_valid, timeout;

  int tests = 0;
  int fails = 0;
  logic [N-1:0] exp_g;

  shared_reg_arbiter #(.N(N), .WIDTH(W), .MAX_HOLD(16)) dut (
    .clk(clk), .rst(rst), .req(req), .wr_en(wr_en), .wdata(wdata),
    .gnt(gnt), .owner_id(owner_id), .q(q), .q_valid(q_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; req = '0; wr_en = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_owner", 32'(owner_id), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_qv", 32'(q_valid), 0);
    chk("rst_to", 32'(timeout), 0);
    rst = 1'b1;

    // single requester with one write
    req = 4'b0100;
    tick();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_owner", 32'(owner_id), 2);
    wr_en = 4'b0100; wdata[2*W +: W] = 8'hA5;
    tick();
    chk("single_q", 32'(q), 32'hA5);
    chk("single_qv", 32'(q_valid), 1);
    chk("single_gnt_hold", 32'(gnt), 32'h4);
    wr_en = '0; req = '0;
    tick();
    chk("release_gnt", 32'(gnt), 0);
    wr_en = 4'b1111; wdata = {4{8'hEE}};
    tick();
    chk("cooldown_wr_ignored", 32'(q), 32'hA5);

    // non-owner write ignored, owner write accepted
    wr_en = '0; req = 4'b0010;
    tick();
    chk("own1_gnt", 32'(gnt), 32'h2);
    chk("own1_owner", 32'(owner_id), 1);
    wr_en = 4'b1000; wdata[3*W +: W] = 8'h3C;
    tick();
    chk("nonowner_q", 32'(q), 32'hA5);
    chk("nonowner_gnt", 32'(gnt), 32'h2);
    wr_en = 4'b0010; wdata[1*W +: W] = 8'h11;
    tick();
    chk("owner1_q", 32'(q), 32'h11);
    wr_en = '0; req = '0;
    tick();
    tick();

    // reset in the middle of a grant
    req = 4'b0100;
    tick();
    chk("own2_gnt", 32'(gnt), 32'h4);
    wr_en = 4'b0100; wdata[2*W +: W] = 8'h5A;
    tick();
    chk("own2_q", 32'(q), 32'h5A);
    wr_en = '0; rst = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 0);
    chk("midrst_q", 32'(q), 0);
    chk("midrst_qv", 32'(q_valid), 0);
    chk("midrst_owner", 32'(owner_id), 0);
    req = 4'b1111;
    tick();
    chk("inrst_gnt", 32'(gnt), 0);
    rst = 1'b1;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'h1);

    // fairness: all requesting, each owner drops after a few cycles
    for (int k = 0; k < N; k++) begin
      exp_g = 4'b0001 << k;
      tick();
      tick();
      chk("fair_hold", 32'(gnt), 32'(exp_g));
      req[k] = 1'b0;
      tick();
      chk("fair_cooldown", 32'(gnt), 0);
      req[k] = 1'b1;
      tick();
      chk("fair_idle", 32'(gnt), 0);
      tick();
      exp_g = 4'b0001 << ((k + 1) % N);
      chk("fair_next_gnt", 32'(gnt), 32'(exp_g));
      chk("fair_next_owner", 32'(owner_id), 32'((k + 1) % N));
    end

    // timeout: requester 0 holds past MAX_HOLD, requester 3 waiting
    req = 4'b1001;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("to_hold_gnt", 32'(gnt), 32'h1);
      chk("to_hold_pulse", 32'(timeout), 0);
      if (i == 15) begin
        wr_en = 4'b0001; wdata[0 +: W] = 8'h77;
      end
    end
    tick();
    chk("to_gnt_drop", 32'(gnt), 0);
    chk("to_pulse", 32'(timeout), 1);
    chk("to_last_write", 32'(q), 32'h77);
    wr_en = '0;
    tick();
    chk("to_pulse_end", 32'(timeout), 0);
    chk("to_idle_gnt", 32'(gnt), 0);
    tick();
    chk("to_rot_gnt", 32'(gnt), 32'h8);
    chk("to_rot_owner", 32'(owner_id), 3);
    req = 4'b0001;
    tick();
    chk("to_rot_cool", 32'(gnt), 0);
    tick();
    chk("to_rot_idle", 32'(gnt), 0);
    tick();
    chk("to_regrant0", 32'(gnt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
